// File: rtl/mips32_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips32_pkg
// Brief   : Shared MIPS32 constants, fetch entry layout and alignment helper.
// Revision: 1.0 - initial release
// ============================================================================
package mips32_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP              = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(INSTR_BYTES - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Synchronous FIFO with flush, occupancy count and registered head.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo
  import mips32_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH-1:0]   r_head;
  logic [c_ptr_w-1:0] w_rd_next;

  assign w_rd_next = r_rd_ptr + c_ptr_w'(1);
  assign count     = r_count;
  assign head      = r_head;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // The head register only moves when a new element becomes the head, so it
  // keeps its last value while the FIFO is empty or after a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (pop)  r_rd_ptr <= w_rd_next;
      r_count <= r_count + c_cnt_w'(push) - c_cnt_w'(pop);
      if (push && ((r_count == '0) || (pop && (r_count == c_cnt_w'(1))))) begin
        r_head <= push_data;
      end else if (pop && (r_count > c_cnt_w'(1))) begin
        r_head <= r_mem[w_rd_next];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : Credit-limited instruction fetch with redirect flush and drop.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  localparam int                 c_cnt_w = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w:0]   c_depth = (c_cnt_w + 1)'(DEPTH);

  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_rsp_pc;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_drop_cnt;
  logic               r_reset_q;
  logic               r_has_head;

  logic [c_cnt_w-1:0] w_fifo_count;
  fetch_entry_t       w_head;
  fetch_entry_t       w_push_entry;
  logic [c_cnt_w:0]   w_in_flight;
  logic               w_rsp_ok;
  logic               w_req_fire;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_redirect_target;
  logic [c_cnt_w-1:0] w_out_after_rsp;

  assign w_in_flight       = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_rsp_ok          = imem_rsp_valid && (r_outstanding != '0);
  assign w_req_fire        = imem_req_valid && imem_req_ready;
  assign w_push            = w_rsp_ok && (r_drop_cnt == '0) && !redirect_valid;
  assign w_pop             = if_valid && if_ready;
  assign w_redirect_target = word_align(redirect_pc);
  assign w_out_after_rsp   = r_outstanding - c_cnt_w'(w_rsp_ok);
  assign w_push_entry      = '{instr: imem_rsp_data, pc: r_rsp_pc};

  assign imem_req_valid = !r_reset_q && !redirect_valid && (w_in_flight < c_depth);
  assign imem_req_addr  = r_fetch_pc;
  assign if_valid       = (w_fifo_count != '0) && !redirect_valid;
  assign if_instr       = w_head.instr;
  assign if_pc          = w_head.pc;
  assign if_pc_plus4    = r_has_head ? (w_head.pc + INSTR_BYTES) : '0;

  // On redirect every request still in flight after this cycle becomes a
  // drop; earlier pending drops are already part of that in-flight total.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_reset_q     <= 1'b1;
      r_has_head    <= 1'b0;
    end else begin
      r_reset_q <= 1'b0;
      if (w_push) r_has_head <= 1'b1;
      if (redirect_valid) begin
        r_fetch_pc    <= w_redirect_target;
        r_rsp_pc      <= w_redirect_target;
        r_outstanding <= w_out_after_rsp;
        r_drop_cnt    <= w_out_after_rsp;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + INSTR_BYTES;
        r_outstanding <= w_out_after_rsp + c_cnt_w'(w_req_fire);
        if (w_rsp_ok) begin
          if (r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
          else                  r_rsp_pc   <= r_rsp_pc + INSTR_BYTES;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .count     (w_fifo_count),
    .head      (w_head)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch_unit
// Brief   : Scoreboard bench for instr_fetch_unit with a latency memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat_cfg = 1;
  logic        toggle = 1'b0;
  int          n_fire = 0;
  int          n_pop = 0;
  int          first_pop_cyc = 0;
  int          last_pop_cyc = 0;

  instr_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: in-order, fixed latency, responses driven for one cycle.
  always @(negedge clk) begin
    mreq_t m;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m.addr);
    end
    if (toggle) imem_req_ready = ~imem_req_ready;
    #4;
    if (reset) begin
      mem_q.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      m.addr = imem_req_addr;
      m.due  = cyc + lat_cfg;
      mem_q.push_back(m);
      n_fire++;
    end
  end

  // Monitor: every decode handshake is checked against the scoreboard head.
  always @(negedge clk) begin
    logic [31:0] e;
    #4;
    if (if_valid && if_ready) begin
      n_pop++;
      if (n_pop == 1) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h expected none", if_pc);
      end else begin
        e = exp_q.pop_front();
        check("if_pc", if_pc, e);
        check("if_instr", if_instr, mem_word(e));
        check("if_pc_plus4", if_pc_plus4, e + 32'd4);
      end
    end
  end

  task automatic push_seq(input logic [31:0] base, input int n);
    logic [31:0] p;
    p = base;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
    check({tag, "_if_instr"}, if_instr, 32'd0);
    check({tag, "_if_pc"}, if_pc, 32'd0);
    check({tag, "_if_pc_plus4"}, if_pc_plus4, 32'd0);
  endtask

  // Leaves the bench at cycle 0 (+4) of a fresh run after one reset edge.
  task automatic start_test(input int lat, input logic rdy, input logic tog);
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    if_ready = 1'b0; toggle = 1'b0; imem_req_ready = 1'b1; lat_cfg = lat;
    @(negedge clk);
    exp_q.delete(); n_fire = 0; n_pop = 0;
    reset = 1'b0; if_ready = rdy; toggle = tog;
    #4;
    check_zero("reset");
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exp_q.size() != 0 && n < max);
    if_ready = 1'b0;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Free run, latency 1: first delivery in cycle 3, then one per cycle.
    start_test(1, 1'b1, 1'b0);
    push_seq(32'h0, 8);
    @(negedge clk); #4;
    check("t1_req_valid_c1", {31'd0, imem_req_valid}, 32'd1);
    check("t1_req_addr_c1", imem_req_addr, 32'h0);
    @(negedge clk); #4;
    check("t1_if_valid_c2", {31'd0, if_valid}, 32'd0);
    @(negedge clk); #4;
    check("t1_if_valid_c3", {31'd0, if_valid}, 32'd1);
    drain(100);
    check("t1_throughput", last_pop_cyc - first_pop_cyc, 32'd7);

    // Decode stalled: exactly DEPTH requests, then drain in order.
    start_test(1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #4;
    check("t2_fires", n_fire, 32'd4);
    check("t2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("t2_if_valid", {31'd0, if_valid}, 32'd1);
    @(negedge clk);
    push_seq(32'h0, 8);
    if_ready = 1'b1;
    drain(100);

    // Latency 3 with a toggling request ready.
    start_test(3, 1'b1, 1'b1);
    push_seq(32'h0, 10);
    drain(300);
    toggle = 1'b0;

    // Redirect with two requests outstanding; both responses dropped.
    start_test(3, 1'b1, 1'b0);
    push_seq(32'h100, 8);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    check("t4_if_valid_after", {31'd0, if_valid}, 32'd0);
    check("t4_req_valid_after", {31'd0, imem_req_valid}, 32'd1);
    check("t4_req_addr_after", imem_req_addr, 32'h100);
    drain(100);

    // Redirect coinciding with a response and a pending decode pop.
    start_test(1, 1'b1, 1'b0);
    push_seq(32'h0, 3);
    push_seq(32'h200, 8);
    repeat (6) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #4;
    check("t5_rsp_in_redirect", {31'd0, imem_rsp_valid}, 32'd1);
    check("t5_if_valid_redirect", {31'd0, if_valid}, 32'd0);
    check("t5_req_valid_redirect", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    drain(100);

    // Back-to-back redirects: the last target wins, drops not double counted.
    start_test(3, 1'b1, 1'b0);
    push_seq(32'h400, 6);
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect_pc = 32'h400;
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    check("t6_req_addr", imem_req_addr, 32'h400);
    drain(100);

    // Address wrap, then reset mid-burst.
    start_test(1, 1'b1, 1'b0);
    push_seq(32'hFFFF_FFF8, 4);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    drain(100);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #4;
    check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #4;
    check("t7_restart_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t7_restart_addr", imem_req_addr, 32'h0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
